// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: decodes HI/LO multiply-divide ops in EX, issues them to the unit,
// stalls while its busy window is open and keeps saturating issue/stall counters.
module md_issue_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [3:0]       ex_op,
    input  logic             divisor_zero,
    output logic [1:0]       md_start,
    output logic [1:0]       md_op,
    output logic             hi_we,
    output logic             lo_we,
    output logic             hilo_sel,
    output logic             stall,
    output logic             busy,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int LAT_MAX = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(LAT_MAX + 1);
    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic md_req, go, mul_start, div_start, hilo_q;
    // Every md op stalls while busy, so strobes only need the not-busy qualifier.
    always_comb begin
        md_req = ex_valid && ex_op >= 4'd1 && ex_op <= 4'd8;
        busy = state != IDLE;
        stall = md_req && busy;
        go = ex_valid && !busy;
        mul_start = go && (ex_op == 4'd1 || ex_op == 4'd2);
        div_start = go && (ex_op == 4'd3 || ex_op == 4'd4) && !divisor_zero;
        md_start = {div_start, mul_start};
        md_op = mul_start ? {1'b0, ex_op == 4'd2} : div_start ? {1'b1, ex_op == 4'd4} : 2'b00;
        hi_we = go && ex_op == 4'd7;
        lo_we = go && ex_op == 4'd8;
        hilo_sel = (go && ex_op == 4'd5) ? 1'b0 : (go && ex_op == 4'd6) ? 1'b1 : hilo_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            hilo_q <= 1'b0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            hilo_q <= hilo_sel;
            if (md_start != 2'b00 && !(&issue_cnt)) issue_cnt <= issue_cnt + 1'b1;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (busy) begin
                state <= cnt == '0 ? IDLE : state;
                cnt <= cnt == '0 ? cnt : cnt - 1'b1;
            end else if (mul_start) begin
                state <= MUL_BUSY;
                cnt <= CW'(MUL_CYCLES - 1);
            end else if (div_start) begin
                state <= DIV_BUSY;
                cnt <= CW'(DIV_CYCLES - 1);
            end
        end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: table-driven cycle vectors plus reset and counter-saturation sequences.
module tb_md_issue_ctrl;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;
    logic clk = 1'b0, reset = 1'b1, ex_valid = 1'b0, divisor_zero = 1'b0;
    logic [3:0] ex_op = 4'd0;
    logic [1:0] md_start, md_op, md_start4, md_op4;
    logic hi_we, lo_we, hilo_sel, stall, busy, hi_we4, lo_we4, hilo_sel4, stall4, busy4;
    logic [15:0] issue_cnt, stall_cnt;
    logic [3:0] issue_cnt4, stall_cnt4;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    md_issue_ctrl dut (.clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .divisor_zero(divisor_zero), .md_start(md_start), .md_op(md_op), .hi_we(hi_we),
        .lo_we(lo_we), .hilo_sel(hilo_sel), .stall(stall), .busy(busy),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt));
    md_issue_ctrl #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .divisor_zero(divisor_zero), .md_start(md_start4), .md_op(md_op4), .hi_we(hi_we4),
        .lo_we(lo_we4), .hilo_sel(hilo_sel4), .stall(stall4), .busy(busy4),
        .issue_cnt(issue_cnt4), .stall_cnt(stall_cnt4));

    typedef struct packed {
        logic [1:0] st; logic [1:0] op; logic hw; logic lw; logic hs; logic stl; logic bsy;
        logic [15:0] ic; logic [15:0] sc;
    } out_t;
    typedef struct {logic v; logic [3:0] op; logic dz; out_t exp;} vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [3:0] op, logic dz, logic [1:0] st, logic [1:0] mo,
                                logic hw, logic lw, logic hs, logic stl, logic bsy,
                                logic [15:0] ic, logic [15:0] sc);
        vec_t r;
        r.v = v; r.op = op; r.dz = dz;
        r.exp = '{st: st, op: mo, hw: hw, lw: lw, hs: hs, stl: stl, bsy: bsy, ic: ic, sc: sc};
        return r;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [3:0] op, input logic dz);
        @(negedge clk);
        reset = r; ex_valid = v; ex_op = op; divisor_zero = dz;
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        out_t act;
        int n;
        // MULT then MFLO held through the busy window
        tbl.push_back(mk(1, MULT, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1'b0, 0));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1, MFLO, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'(i - 1)));
        tbl.push_back(mk(1, MFLO, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5));
        tbl.push_back(mk(0, MFLO, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5));
        tbl.push_back(mk(0, MULT, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5));
        // DIVU, then MTHI from cycle 3 stalls until the window closes
        tbl.push_back(mk(1, DIVU, 0, 2'b10, 2'b11, 0, 0, 1, 0, 0, 1, 5));
        tbl.push_back(mk(0, NONE, 0, 0, 0, 0, 0, 1, 0, 1, 2, 5));
        tbl.push_back(mk(1, NONE, 0, 0, 0, 0, 0, 1, 0, 1, 2, 5));
        for (int i = 3; i <= 10; i++) tbl.push_back(mk(1, MTHI, 0, 0, 0, 0, 0, 1, 1, 1, 2, 16'(5 + i - 3)));
        tbl.push_back(mk(1, MTHI, 0, 0, 0, 1, 0, 1, 0, 0, 2, 13));
        // divide by zero never issues; MFHI after it does not stall
        tbl.push_back(mk(1, DIV, 1, 0, 0, 0, 0, 1, 0, 0, 2, 13));
        tbl.push_back(mk(1, MFHI, 0, 0, 0, 0, 0, 0, 0, 0, 2, 13));
        tbl.push_back(mk(1, 4'd12, 0, 0, 0, 0, 0, 0, 0, 0, 2, 13));
        // MULT, ADD-class ops during busy, MULTU right after busy drops
        tbl.push_back(mk(1, MULT, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2, 13));
        tbl.push_back(mk(1, 4'd12, 0, 0, 0, 0, 0, 0, 0, 1, 3, 13));
        tbl.push_back(mk(1, NONE, 0, 0, 0, 0, 0, 0, 0, 1, 3, 13));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, NONE, 0, 0, 0, 0, 0, 0, 0, 1, 3, 13));
        tbl.push_back(mk(1, MULTU, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 3, 13));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, MTLO, 0, 0, 0, 0, 0, 0, 1, 1, 4, 16'(13 + i)));
        tbl.push_back(mk(1, MTLO, 0, 0, 0, 0, 1, 0, 0, 0, 4, 18));
        tbl.push_back(mk(0, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 4, 18));

        drive(1, 0, NONE, 0);
        drive(1, 0, NONE, 0);
        foreach (tbl[i]) begin
            drive(0, tbl[i].v, tbl[i].op, tbl[i].dz);
            act = {md_start, md_op, hi_we, lo_we, hilo_sel, stall, busy, issue_cnt, stall_cnt};
            chk($sformatf("row%0d", i), 64'(act), 64'(tbl[i].exp));
        end

        // reset in cycle 4 of a DIV; the reset-cycle MULT is neither counted nor latched
        drive(0, 1, DIV, 0);
        chk("rst_div_start", 64'(md_start), 64'(2'b10));
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, NONE, 0);
            chk($sformatf("rst_busy%0d", i), 64'(busy), 64'(1));
        end
        drive(1, 1, MULT, 0);
        chk("rst_cycle_stall", 64'(stall), 64'(1));
        drive(0, 1, MFLO, 0);
        chk("rst_after", 64'({busy, stall, hilo_sel, issue_cnt, stall_cnt, stall_cnt4}),
            64'({1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 4'd0}));

        // four back-to-back MULTs with 5 stall cycles each: 4-bit stall_cnt saturates
        n = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, MULT, 0);
            chk($sformatf("b2b_start%0d", k), 64'({md_start, md_op}), 64'({2'b01, 2'b00}));
            for (int j = 0; j < 5; j++) begin
                drive(0, 1, MFLO, 0);
                chk($sformatf("sat_cnt%0d", n), 64'({stall, stall_cnt4}), 64'({1'b1, 4'(n > 15 ? 15 : n)}));
                n++;
            end
        end
        drive(0, 0, NONE, 0);
        chk("sat_final", 64'({stall_cnt4, stall_cnt, issue_cnt, issue_cnt4}),
            64'({4'd15, 16'd20, 16'd4, 4'd4}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
